// File: rtl/reg_wb_pkg.sv
// rtl/reg_wb_pkg.sv - shared constants and types for the register writeback controller
package reg_wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int CNT_W    = 2;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int ZERO_REG = 0;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0]  pend_cnt_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write counters, issue back-pressure and RAW stall query (optional WB_BYPASS_EN)
module reg_scoreboard
    import reg_wb_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     issValid,
    input  logic     issWr,
    input  reg_idx_t issDst,
    output logic     issReady,
    input  logic     wbWe,
    input  reg_idx_t wbAddr,
    input  reg_idx_t qSrc1,
    input  reg_idx_t qSrc2,
    output logic     stall
);

    pend_cnt_t           cnt [NUM_REGS];
    logic                issAccept;
    logic [NUM_REGS-1:0] incVec;
    logic [NUM_REGS-1:0] decVec;
    logic                busy1;
    logic                busy2;

    // A writing issue is refused only while its destination counter is full
    always_comb begin
        issReady  = !(issWr && (cnt[issDst] == pend_cnt_t'(CNT_MAX)));
        issAccept = issValid && issWr && issReady;
    end

    // Decode the accepted issue and the current writeback into per-register events; r0 never counts
    always_comb begin
        incVec = '0;
        decVec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            incVec[r] = issAccept && (issDst == reg_idx_t'(r));
            decVec[r] = wbWe && (wbAddr == reg_idx_t'(r));
        end
    end

    // Counter array: simultaneous inc/dec cancel, decrement at zero is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (incVec[r] && !decVec[r]) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (decVec[r] && !incVec[r] && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    // RAW query: a source is busy while any producer is outstanding, unless the
    // last one is being written this cycle and the negedge commit beats the read
    always_comb begin
        busy1 = (cnt[qSrc1] != '0);
        busy2 = (cnt[qSrc2] != '0);
`ifdef WB_BYPASS_EN
        if ((cnt[qSrc1] == pend_cnt_t'(1)) && wbWe && (wbAddr == qSrc1)) begin
            busy1 = 1'b0;
        end
        if ((cnt[qSrc2] == pend_cnt_t'(1)) && wbWe && (wbAddr == qSrc2)) begin
            busy2 = 1'b0;
        end
`else
        busy1 = busy1;
        busy2 = busy2;
`endif
        stall = busy1 || busy2;
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// rtl/reg_writeback_ctrl.sv - MEM/WB register, writeback mux and register-file write port (optional WB_BYPASS_EN)
module reg_writeback_ctrl
    import reg_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    input  logic              iss_wr,
    input  logic [ADDR_W-1:0] iss_dst,
    output logic              iss_ready,
    input  logic              mem_valid,
    input  logic              mem_wr,
    input  logic              mem_to_reg,
    input  logic [ADDR_W-1:0] mem_dst,
    input  logic [DATA_W-1:0] mem_alu,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [ADDR_W-1:0] q_src1,
    input  logic [ADDR_W-1:0] q_src2,
    output logic              stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    reg_data_t wbData;
    logic      wbWrite;

    // Writeback source select and write qualification; writes to r0 are dropped here
    always_comb begin
        wbData  = mem_to_reg ? mem_rdata : mem_alu;
        wbWrite = mem_valid && mem_wr && (mem_dst != reg_idx_t'(ZERO_REG));
    end

    // MEM/WB pipeline register driving the register-file port for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we    <= wbWrite;
            rf_waddr <= mem_dst;
            rf_wdata <= wbData;
        end
    end

    reg_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .issValid (iss_valid),
        .issWr    (iss_wr),
        .issDst   (iss_dst),
        .issReady (iss_ready),
        .wbWe     (rf_we),
        .wbAddr   (rf_waddr),
        .qSrc1    (q_src1),
        .qSrc2    (q_src2),
        .stall    (stall)
    );

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb/tb_reg_writeback_ctrl.sv - scoreboard testbench for reg_writeback_ctrl (honours WB_BYPASS_EN)
module tb_reg_writeback_ctrl;

    localparam int MAXP = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid, iss_wr, iss_ready;
    logic [4:0]  iss_dst;
    logic        mem_valid, mem_wr, mem_to_reg;
    logic [4:0]  mem_dst;
    logic [31:0] mem_alu, mem_rdata;
    logic [4:0]  q_src1, q_src2;
    logic        stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t expQ[$];
    int  inflight[$];
    int  pending[32];
    bit  wbValid;
    int  wbAddr;
    int  checks = 0;
    int  errors = 0;

    reg_writeback_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_dst(iss_dst), .iss_ready(iss_ready),
        .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_to_reg(mem_to_reg), .mem_dst(mem_dst),
        .mem_alu(mem_alu), .mem_rdata(mem_rdata),
        .q_src1(q_src1), .q_src2(q_src2), .stall(stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit srcStall(input int s);
        if (pending[s] == 0) return 1'b0;
`ifdef WB_BYPASS_EN
        if (pending[s] == 1 && wbValid && wbAddr == s) return 1'b0;
`endif
        return 1'b1;
    endfunction

    // Reference model: outstanding producers per register and the write on the port
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (pending[i]) pending[i] = 0;
            wbValid = 1'b0;
            wbAddr  = 0;
            expQ.delete();
        end else begin
            if (iss_valid && iss_wr && iss_dst != 0 && pending[iss_dst] < MAXP)
                pending[iss_dst]++;
            if (wbValid && pending[wbAddr] > 0)
                pending[wbAddr]--;
            wbValid = mem_valid && mem_wr && (mem_dst != 0);
            wbAddr  = int'(mem_dst);
        end
    end

    // Monitor: compare port activity and combinational queries mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rf_we", 32'(rf_we), 32'(wbValid));
            if (rf_we) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_write", 32'(1), 32'(0));
                end else begin
                    wr_t e;
                    e = expQ.pop_front();
                    chk("rf_waddr", 32'(rf_waddr), 32'(e.addr));
                    chk("rf_wdata", rf_wdata, e.data);
                end
            end
            chk("stall", 32'(stall), 32'(srcStall(int'(q_src1)) || srcStall(int'(q_src2))));
            chk("iss_ready", 32'(iss_ready), 32'(!(iss_wr && pending[iss_dst] == MAXP)));
        end
    end

    task automatic step(input bit iv, input bit iw, input int id,
                        input bit mv, input bit mw, input bit mtr, input int md,
                        input logic [31:0] alu, input logic [31:0] rd,
                        input int s1, input int s2);
        @(posedge clk);
        #1;
        iss_valid  = iv;  iss_wr = iw;  iss_dst = 5'(id);
        mem_valid  = mv;  mem_wr = mw;  mem_to_reg = mtr; mem_dst = 5'(md);
        mem_alu    = alu; mem_rdata = rd;
        q_src1     = 5'(s1); q_src2 = 5'(s2);
        if (mv && mw && md != 0) expQ.push_back('{md, mtr ? rd : alu});
    endtask

    task automatic idle(input int s1, input int s2);
        step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, s1, s2);
    endtask

    initial begin
        rst_n = 1'b0;
        iss_valid = 0; iss_wr = 0; iss_dst = 0;
        mem_valid = 0; mem_wr = 0; mem_to_reg = 0; mem_dst = 0;
        mem_alu = 0; mem_rdata = 0; q_src1 = 0; q_src2 = 0;
        #12;
        chk("reset_rf_we", 32'(rf_we), 32'(0));
        chk("reset_rf_waddr", 32'(rf_waddr), 32'(0));
        chk("reset_rf_wdata", rf_wdata, 32'h0);
        chk("reset_stall", 32'(stall), 32'(0));
        chk("reset_iss_ready", 32'(iss_ready), 32'(1));
        #10 rst_n = 1'b1;

        // ALU write to r5
        step(1, 1, 5, 0, 0, 0, 0, 32'h0, 32'h0, 5, 0);
        step(0, 0, 0, 1, 1, 0, 5, 32'h1234_5678, 32'hAAAA_0000, 5, 0);
        idle(5, 0);
        idle(5, 0);

        // Load to r8, then a write to r0
        step(1, 1, 8, 0, 0, 0, 0, 32'h0, 32'h0, 8, 0);
        step(1, 1, 0, 1, 1, 1, 8, 32'h40, 32'hDEAD_BEEF, 8, 0);
        step(0, 0, 0, 1, 1, 0, 0, 32'h5555_5555, 32'h0, 0, 8);
        idle(0, 0);

        // RAW hazard on r3 through writeback
        step(1, 1, 3, 0, 0, 0, 0, 32'h0, 32'h0, 3, 0);
        idle(3, 0);
        idle(3, 0);
        step(0, 0, 0, 1, 1, 0, 3, 32'h0000_0033, 32'h0, 3, 0);
        idle(3, 0);
        idle(3, 0);

        // Saturate r7
        for (int i = 0; i < 3; i++) step(1, 1, 7, 0, 0, 0, 0, 32'h0, 32'h0, 0, 7);
        step(1, 1, 7, 0, 0, 0, 0, 32'h0, 32'h0, 0, 7);
        #1 chk("sat_ready_low", 32'(iss_ready), 32'(0));
        step(1, 1, 7, 1, 1, 0, 7, 32'h0000_0777, 32'h0, 0, 7);
        step(1, 1, 7, 0, 0, 0, 0, 32'h0, 32'h0, 0, 7);
        #1 chk("sat_ready_wb_cycle", 32'(iss_ready), 32'(0));
        step(0, 0, 0, 1, 1, 0, 7, 32'h0000_0771, 32'h0, 0, 7);
        step(0, 0, 0, 1, 1, 1, 7, 32'h0, 32'h0000_0772, 0, 7);
        idle(0, 7);
        idle(0, 7);

        // Issue and writeback of r2 in the same cycle
        step(1, 1, 2, 0, 0, 0, 0, 32'h0, 32'h0, 2, 0);
        step(0, 0, 0, 1, 1, 0, 2, 32'h0000_0222, 32'h0, 2, 0);
        step(1, 1, 2, 0, 0, 0, 0, 32'h0, 32'h0, 2, 0);
        idle(2, 0);
        #1 chk("r2_still_stalled", 32'(stall), 32'(1));
        step(0, 0, 0, 1, 1, 0, 2, 32'h0000_0223, 32'h0, 2, 0);
        idle(2, 0);
        idle(2, 0);

        // Asynchronous reset during a writeback
        step(1, 1, 9, 0, 0, 0, 0, 32'h0, 32'h0, 9, 0);
        step(0, 0, 0, 1, 1, 0, 9, 32'h0000_0999, 32'h0, 9, 0);
        idle(9, 0);
        #1 chk("pre_reset_rf_we", 32'(rf_we), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("async_rf_we", 32'(rf_we), 32'(0));
        chk("async_stall", 32'(stall), 32'(0));
        chk("async_iss_ready", 32'(iss_ready), 32'(1));
        @(negedge clk);
        #2 rst_n = 1'b1;
        inflight.delete();

        // Randomized traffic with protocol-correct completions
        for (int c = 0; c < 600; c++) begin
            bit iv, iw, mv, mw, mtr;
            int id, md;
            iv = ($urandom % 4) != 0;
            iw = ($urandom % 4) != 0;
            id = int'($urandom % 8);
            mv = 0; mw = 0; md = int'($urandom % 8);
            mtr = $urandom % 2;
            if (inflight.size() != 0 && ($urandom % 2) == 1) begin
                md = inflight.pop_front();
                mv = 1; mw = 1;
            end else if (($urandom % 8) == 0) begin
                mv = 1; mw = 0;
            end
            step(iv, iw, id, mv, mw, mtr, md, $urandom, $urandom,
                 int'($urandom % 8), int'($urandom % 8));
            if (iv && iw && !(id != 0 && pending[id] == MAXP)) inflight.push_back(id);
        end
        while (inflight.size() != 0) begin
            int md;
            md = inflight.pop_front();
            step(0, 0, 0, 1, 1, 0, md, $urandom, $urandom, md, 0);
        end
        idle(0, 0);
        idle(0, 0);
        @(posedge clk);
        #1 chk("queue_drained", 32'(expQ.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
